bin_to_bcd: RTL and testbench
=============================

BIN_TO_BCD -- requirements
Module: bin_to_bcd

Interface
REQ-001 Parameter WIDTH, default 8: binary input width in bits; legal range >= 2.
REQ-002 Parameter DIGITS, default 3: number of BCD output digits; legal range >= 1.
REQ-003 Port clk, input, 1: the block's single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port in_valid, input, 1: in_data holds a value to convert.
REQ-006 Port in_ready, output, 1: block can accept a value this cycle.
REQ-007 Port in_data, input, WIDTH: binary value to convert.
REQ-008 Port out_valid, output, 1: out_digits, out_sign and out_ovf hold a finished result.
REQ-009 Port out_ready, input, 1: consumer takes the result this cycle.
REQ-010 Port out_digits, output, DIGITS x 4, packed; digit 0 is least significant.
REQ-011 Port out_sign, output, 1: result is negative.
REQ-012 Port out_ovf, output, 1: magnitude >= 10^DIGITS; out_digits are invalid when set.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-014 in_ready SHALL be 1 in IDLE only; out_valid SHALL be 1 in DONE only.
REQ-015 Accept (in_valid && in_ready) SHALL load the magnitude into the binary shift register, clear the BCD register, clear the overflow flag, latch the sign, zero the counter and move to SHIFT.
REQ-016 Each SHIFT cycle SHALL add 3 to every BCD digit > 4, then shift {BCD, binary} left one bit and increment the counter.
REQ-017 The sticky overflow flag SHALL be set whenever the bit shifted out of the BCD register MSB is 1.
REQ-018 After the WIDTH-th shift the FSM SHALL enter DONE, so out_valid rises exactly WIDTH cycles after the accept edge.
REQ-019 In DONE, all outputs SHALL stay stable while out_ready is 0, for any number of cycles.
REQ-020 In DONE with out_ready = 1, the FSM SHALL return to IDLE on that edge; the next accept is possible one cycle later.
REQ-021 in_valid SHALL be ignored outside IDLE; in_data SHALL be sampled only on the accept edge.
REQ-022 The counter SHALL be $clog2(WIDTH+1) bits wide and SHALL never wrap within a conversion.
REQ-023 Input 0 SHALL still take WIDTH cycles and give all-zero digits, out_ovf = 0.

Reset
REQ-024 rst = 1 at a clock edge SHALL force IDLE and clear the BCD register, binary register, counter, overflow flag and sign, in any state.
REQ-025 During and after reset: in_ready = 0 while rst = 1, then 1 on the first cycle after rst deasserts; out_valid = 0, out_digits = 0, out_sign = 0, out_ovf = 0.
REQ-026 Reset SHALL take priority over a simultaneous accept or out_ready.
REQ-027 A conversion interrupted by reset SHALL be discarded and never produce out_valid.

Configuration
REQ-028 Macro BIN_TO_BCD_SIGNED_EN defined: in_data is two's complement.
 - out_sign = in_data MSB at accept.
 - The WIDTH-bit unsigned magnitude is converted.
 - -2^(WIDTH-1) SHALL convert correctly.
REQ-029 Macro BIN_TO_BCD_SIGNED_EN undefined: in_data is unsigned, out_sign is tied 0, and no negation logic is built.

Structure
REQ-030 Package bcd_pkg SHALL hold:
 - typedef bcd_digit_t (logic [3:0]);
 - the FSM state enum bcd_state_t {IDLE, SHIFT, DONE};
 - the constant BCD_ADJ_THRESHOLD = 4.
REQ-031 Sub-module bcd_digit_adj SHALL implement the combinational add-3-if-greater-than-4 cell; one instance per digit, generated.

Verification
REQ-032 Unsigned, WIDTH=8, DIGITS=3: accept 255 -> out_valid exactly 8 cycles later, digits 2,5,5, out_ovf = 0.
REQ-033 Unsigned, WIDTH=8, DIGITS=2: accept 100 -> out_ovf = 1; accept 99 -> digits 9,9, out_ovf = 0.
REQ-034 Backpressure: out_ready held 0 for 5 cycles in DONE -> outputs unchanged, in_ready = 0; out_ready = 1 -> IDLE next cycle, in_ready = 1.
REQ-035 rst pulsed at SHIFT cycle 3 of 8 -> next cycle IDLE, all outputs 0, no out_valid; a fresh accept of 42 -> digits 0,4,2.
REQ-036 BIN_TO_BCD_SIGNED_EN defined, WIDTH=8, DIGITS=3:
 - accept 0x80 -> out_sign = 1, digits 1,2,8;
 - accept 0xFF -> out_sign = 1, digits 0,0,1.
REQ-037 Back-to-back: in_valid held 1 with out_ready held 1 -> one accept every WIDTH+2 cycles, with each input producing exactly one result.

Source files
------------

// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_pkg
//  Purpose  : Shared types and constants for the binary-to-BCD converter.
//  Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    localparam bcd_digit_t BCD_ADJ_THRESHOLD = 4'd4;
    localparam bcd_digit_t BCD_ADJ_ADDEND    = 4'd3;

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_digit_adj
//  Purpose  : Double-dabble correction cell: adds 3 to a BCD digit above 4.
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  bcd_digit_t i_digit,
    output bcd_digit_t o_digit
);

    always_comb begin
        o_digit = i_digit;
        if (i_digit > BCD_ADJ_THRESHOLD) begin
            o_digit = i_digit + BCD_ADJ_ADDEND;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bin_to_bcd.sv
`default_nettype none
// ============================================================================
//  Module   : bin_to_bcd
//  Purpose  : Sequential double-dabble binary-to-BCD converter with
//             valid/ready handshakes; one input bit per SHIFT cycle.
//             Define BIN_TO_BCD_SIGNED_EN for two's-complement input.
//  Revision : 1.0 - initial release
// ============================================================================
module bin_to_bcd
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIGITS*4-1:0]   out_digits,
    output logic                  out_sign,
    output logic                  out_ovf
);

    localparam int              BCD_W    = DIGITS * 4;
    localparam int              CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    bcd_state_t         state_q, state_d;
    logic [BCD_W-1:0]   bcd_q,   bcd_d;
    logic [WIDTH-1:0]   bin_q,   bin_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               ovf_q,   ovf_d;

    logic [BCD_W-1:0]   w_bcd_adj;
    logic [WIDTH-1:0]   w_mag;
    logic               w_accept;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_digit_adj u_adj (
                .i_digit (bcd_q[4*gi +: 4]),
                .o_digit (w_bcd_adj[4*gi +: 4])
            );
        end
    endgenerate

`ifdef BIN_TO_BCD_SIGNED_EN
    logic sign_q, sign_d;
    // Unsigned reading of the negation makes -2^(WIDTH-1) come out right.
    assign w_mag = in_data[WIDTH-1] ? (-in_data) : in_data;
`else
    assign w_mag = in_data;
`endif

    assign in_ready = (state_q == IDLE) && !rst;
    assign w_accept = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
`ifdef BIN_TO_BCD_SIGNED_EN
        sign_d  = sign_q;
`endif
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    bin_d   = w_mag;
                    bcd_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
`ifdef BIN_TO_BCD_SIGNED_EN
                    sign_d  = in_data[WIDTH-1];
`endif
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = {w_bcd_adj[BCD_W-2:0], bin_q[WIDTH-1]};
                bin_d = {bin_q[WIDTH-2:0], 1'b0};
                ovf_d = ovf_q | w_bcd_adj[BCD_W-1];
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bcd_q   <= '0;
            bin_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
`ifdef BIN_TO_BCD_SIGNED_EN
            sign_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
`ifdef BIN_TO_BCD_SIGNED_EN
            sign_q  <= sign_d;
`endif
        end
    end

    assign out_valid  = (state_q == DONE);
    assign out_digits = bcd_q;
    assign out_ovf    = ovf_q;
`ifdef BIN_TO_BCD_SIGNED_EN
    assign out_sign   = sign_q;
`else
    assign out_sign   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bin_to_bcd
//  Purpose  : Self-checking bench for bin_to_bcd (3-digit and 2-digit builds).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd;

    localparam int W  = 8;
    localparam int DA = 3;
    localparam int DB = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic           a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_sign, a_out_ovf;
    logic [W-1:0]   a_in_data;
    logic [DA*4-1:0] a_out_digits;
    logic           b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_sign, b_out_ovf;
    logic [W-1:0]   b_in_data;
    logic [DB*4-1:0] b_out_digits;

    bin_to_bcd #(.WIDTH(W), .DIGITS(DA)) u_dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_digits(a_out_digits), .out_sign(a_out_sign), .out_ovf(a_out_ovf)
    );

    bin_to_bcd #(.WIDTH(W), .DIGITS(DB)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_digits(b_out_digits), .out_sign(b_out_sign), .out_ovf(b_out_ovf)
    );

    typedef struct packed {
        logic [11:0] digits;
        logic        sign;
        logic        ovf;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic exp_t model(input logic [W-1:0] v, input int nd);
        exp_t e;
        int   mag;
        int   rem;
        e   = '0;
        mag = int'(v);
`ifdef BIN_TO_BCD_SIGNED_EN
        if (v[W-1]) begin
            e.sign = 1'b1;
            mag    = (1 << W) - int'(v);
        end
`endif
        e.ovf = (mag >= 10 ** nd);
        rem   = mag;
        for (int i = 0; i < nd; i++) begin
            e.digits[4*i +: 4] = 4'(rem % 10);
            rem = rem / 10;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (a_in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_ready got=%b want=0", a_in_ready);
        end
        n_tests++;
        if ({a_out_valid, a_out_digits, a_out_sign, a_out_ovf} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got valid=%b dig=%h sign=%b ovf=%b want all 0",
                     a_out_valid, a_out_digits, a_out_sign, a_out_ovf);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (a_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready got=%b want=1", a_in_ready);
        end
    endtask

    task automatic do_convert_a(input logic [W-1:0] v, input int hold);
        exp_t e;
        int   cyc;
        cyc = 0;
        while (!a_in_ready && cyc < 20) begin tick(); cyc++; end
        n_tests++;
        if (a_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL wait_ready_a got=%b want=1", a_in_ready);
            return;
        end
        a_in_valid = 1'b1;
        a_in_data  = v;
        sb_a.push_back(model(v, DA));
        tick();
        // Keep in_valid high with junk data; the busy converter must ignore it.
        a_in_data = ~v;
        cyc = 0;
        while (!a_out_valid && cyc < 40) begin tick(); cyc++; end
        a_in_valid = 1'b0;
        n_tests++;
        if (cyc !== W) begin
            n_fail++; $display("FAIL latency_a in=%0d got=%0d want=%0d", v, cyc, W);
        end
        n_tests++;
        if (sb_a.size() == 0) begin
            n_fail++; $display("FAIL scoreboard_a got=empty want=entry");
            return;
        end
        e = sb_a.pop_front();
        for (int h = 0; h <= hold; h++) begin
            n_tests++;
            if ({a_out_valid, a_in_ready, a_out_digits, a_out_sign, a_out_ovf} !==
                {1'b1, 1'b0, e.digits, e.sign, e.ovf}) begin
                n_fail++;
                $display("FAIL result_a in=%0d hold=%0d got v=%b rdy=%b dig=%h s=%b o=%b want v=1 rdy=0 dig=%h s=%b o=%b",
                         v, h, a_out_valid, a_in_ready, a_out_digits, a_out_sign, a_out_ovf,
                         e.digits, e.sign, e.ovf);
            end
            if (h < hold) tick();
        end
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        n_tests++;
        if ({a_out_valid, a_in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL release_a got valid=%b ready=%b want valid=0 ready=1",
                               a_out_valid, a_in_ready);
        end
    endtask

    task automatic do_convert_b(input logic [W-1:0] v);
        exp_t e;
        int   cyc;
        cyc = 0;
        while (!b_in_ready && cyc < 20) begin tick(); cyc++; end
        b_in_valid = 1'b1;
        b_in_data  = v;
        sb_b.push_back(model(v, DB));
        tick();
        b_in_valid = 1'b0;
        cyc = 0;
        while (!b_out_valid && cyc < 40) begin tick(); cyc++; end
        n_tests++;
        if (b_out_valid !== 1'b1 || sb_b.size() == 0) begin
            n_fail++; $display("FAIL timeout_b in=%0d got valid=%b want 1", v, b_out_valid);
            return;
        end
        e = sb_b.pop_front();
        n_tests++;
        if (b_out_ovf !== e.ovf) begin
            n_fail++; $display("FAIL ovf_b in=%0d got=%b want=%b", v, b_out_ovf, e.ovf);
        end
        if (!e.ovf) begin
            n_tests++;
            if (b_out_digits !== e.digits[7:0]) begin
                n_fail++; $display("FAIL digits_b in=%0d got=%h want=%h", v, b_out_digits, e.digits[7:0]);
            end
        end
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
    endtask

    task automatic test_basic();
        logic [W-1:0] vals [6];
        vals = '{8'd255, 8'd0, 8'd42, 8'd9, 8'd100, 8'd128};
        foreach (vals[i]) do_convert_a(vals[i], 0);
    endtask

    task automatic test_signed_edges();
        do_convert_a(8'h80, 0);
        do_convert_a(8'hFF, 0);
        do_convert_a(8'h7F, 0);
    endtask

    task automatic test_backpressure();
        do_convert_a(8'd173, 5);
    endtask

    task automatic test_overflow();
        do_convert_b(8'd100);
        do_convert_b(8'd99);
        do_convert_b(8'd7);
    endtask

    task automatic test_reset_mid();
        int seen;
        while (!a_in_ready) tick();
        a_in_valid = 1'b1;
        a_in_data  = 8'd200;
        tick();
        a_in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        n_tests++;
        if ({a_out_valid, a_in_ready, a_out_digits, a_out_sign, a_out_ovf} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid got v=%b rdy=%b dig=%h s=%b o=%b want all 0",
                     a_out_valid, a_in_ready, a_out_digits, a_out_sign, a_out_ovf);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (a_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_ready got=%b want=1", a_in_ready);
        end
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (a_out_valid) seen++;
            tick();
        end
        n_tests++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL reset_mid_discard got=%0d valid cycles want=0", seen);
        end
        do_convert_a(8'd42, 0);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] vals [4];
        int cyc, idx, got, last;
        logic acc;
        exp_t e;
        vals = '{8'd17, 8'd250, 8'd3, 8'd199};
        cyc = 0; idx = 0; got = 0; last = -1;
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_data   = vals[0];
        while (got < 4 && cyc < 200) begin
            acc = a_in_valid && a_in_ready;
            if (acc) begin
                sb_a.push_back(model(a_in_data, DA));
                if (last >= 0) begin
                    n_tests++;
                    if (cyc - last !== W + 2) begin
                        n_fail++; $display("FAIL b2b_interval got=%0d want=%0d", cyc - last, W + 2);
                    end
                end
                last = cyc;
            end
            if (a_out_valid) begin
                n_tests++;
                if (sb_a.size() == 0) begin
                    n_fail++; $display("FAIL b2b_extra_result got=%h want=none", a_out_digits);
                end else begin
                    e = sb_a.pop_front();
                    if ({a_out_digits, a_out_sign, a_out_ovf} !== {e.digits, e.sign, e.ovf}) begin
                        n_fail++;
                        $display("FAIL b2b_result got dig=%h s=%b o=%b want dig=%h s=%b o=%b",
                                 a_out_digits, a_out_sign, a_out_ovf, e.digits, e.sign, e.ovf);
                    end
                end
                got++;
            end
            tick();
            cyc++;
            if (acc) begin
                idx++;
                if (idx < 4) a_in_data = vals[idx];
                else         a_in_valid = 1'b0;
            end
        end
        a_out_ready = 1'b0;
        a_in_valid  = 1'b0;
        n_tests++;
        if (got !== 4 || sb_a.size() !== 0) begin
            n_fail++; $display("FAIL b2b_count got=%0d results (%0d pending) want=4 (0 pending)",
                               got, sb_a.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed_edges();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
